// File: rtl/sram_burst_reader.sv
// Burst read master: turns one {addr, len} command into single-beat AXI-lite reads.
// Returned data lands in a small FIFO and leaves as a valid/ready stream.
module sram_burst_reader #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [LEN_WIDTH-1:0]  issue_rem_q, issue_rem_d;
  logic [LEN_WIDTH-1:0]  deliver_rem_q, deliver_rem_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic cmd_fire, ar_fire, r_fire, pop;

  assign cmd_ready   = (state_q == S_IDLE) && !reset;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = !reset;
  assign out_valid   = (count_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign out_last    = out_valid && (deliver_rem_q == LEN_WIDTH'(1));

  // A response with nothing outstanding is a leftover from before a reset.
  assign cmd_fire = cmd_valid && cmd_ready;
  assign ar_fire  = arvalid_q && axi_arready;
  assign r_fire   = axi_rvalid && axi_rready && (inflight_q != '0);
  assign pop      = out_valid && out_ready;

  always_comb begin
    state_d       = state_q;
    araddr_d      = araddr_q;
    done_d        = 1'b0;
    err_d         = err_q | (r_fire && (axi_rresp != 2'b00));
    issue_rem_d   = issue_rem_q - LEN_WIDTH'(ar_fire);
    deliver_rem_d = deliver_rem_q - LEN_WIDTH'(pop);
    inflight_d    = inflight_q + CNT_W'(ar_fire) - CNT_W'(r_fire);
    count_d       = count_q + CNT_W'(r_fire) - CNT_W'(pop);
    if (ar_fire) araddr_d = araddr_q + ADDR_WIDTH'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          araddr_d      = cmd_addr;
          issue_rem_d   = cmd_len;
          deliver_rem_d = cmd_len;
          err_d         = 1'b0;
          if (cmd_len != '0) state_d = S_ISSUE;
          else               done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (issue_rem_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (deliver_rem_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A presented AR already owns a credit, so it is not counted again while held.
    if (arvalid_q && !axi_arready)
      arvalid_d = 1'b1;
    else
      arvalid_d = (state_d == S_ISSUE) && (issue_rem_d != '0) &&
                  (({1'b0, count_d} + {1'b0, inflight_d}) < (CNT_W+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      araddr_q      <= '0;
      arvalid_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      inflight_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      araddr_q      <= araddr_d;
      arvalid_q     <= arvalid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      issue_rem_q   <= issue_rem_d;
      deliver_rem_q <= deliver_rem_d;
      inflight_q    <= inflight_d;
      count_q       <= count_d;
      if (r_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire) mem_q[wr_ptr_q] <= axi_rdata;
  end

endmodule

// File: tb/tb_sram_burst_reader.sv
// Bench for sram_burst_reader: SRAM read-channel model, AR/stream scoreboards,
// a command table plus hand-written backpressure, zero-length, busy and reset sequences.
module tb_sram_burst_reader;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          busy, done, err;
  logic [AW-1:0] axi_araddr;
  logic          axi_arvalid, axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid, axi_rready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  always #5 clk = ~clk;

  sram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct {
    logic [AW-1:0] addr; logic [LW-1:0] len; int or_mode;
    bit ar_rand; bit r_rand; bit err_en; logic [AW-1:0] err_addr;
    logic exp_err; logic [DW-1:0] exp_first;
  } vec_t;

  int          checks = 0;
  int          fails  = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned last_pop_cyc = 0;
  beat_t       exp_q[$];
  logic [AW-1:0] exp_ar[$];
  logic [AW-1:0] rq[$];
  int          ar_allow = -1;
  int          r_allow  = -1;
  bit          ar_rand = 0, r_rand = 0, err_en = 0;
  logic [AW-1:0] err_addr = '0;
  int          ar_cnt = 0;
  int          or_mode = 0;
  bit          first_pending = 0;
  logic [DW-1:0] first_data = '0;
  logic        ar_hold = 1'b0, st_hold = 1'b0, arf, rf;
  logic [AW-1:0] ar_held;
  logic [DW-1:0] st_data;
  vec_t        vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    checks++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // SRAM controller read-channel model; also checks AR addresses and AR hold.
  initial begin
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      arf = axi_arvalid && axi_arready;
      rf  = axi_rvalid && axi_rready;
      if (ar_hold && !reset) begin
        chk("ar_hold_valid", 32'(axi_arvalid), 32'(1));
        chk("ar_hold_addr", 32'(axi_araddr), 32'(ar_held));
      end
      ar_hold = axi_arvalid && !axi_arready && !reset;
      ar_held = axi_araddr;
      if (arf) begin
        rq.push_back(axi_araddr);
        ar_cnt++;
        if (ar_allow > 0) ar_allow--;
        if (exp_ar.size() == 0) flag("ar_unexpected");
        else chk("ar_addr", 32'(axi_araddr), 32'(exp_ar.pop_front()));
      end
      @(posedge clk);
      #1;
      if (rf) begin
        void'(rq.pop_front());
        if (r_allow > 0) r_allow--;
      end
      axi_arready = (ar_allow != 0) && (!ar_rand || ($urandom_range(0, 1) == 1));
      if (rq.size() > 0 && r_allow != 0 && (!r_rand || ($urandom_range(0, 2) != 0))) begin
        axi_rvalid = 1'b1;
        axi_rdata  = mem_f(rq[0]);
        axi_rresp  = (err_en && rq[0] == err_addr) ? 2'b10 : 2'b00;
      end else begin
        axi_rvalid = 1'b0;
        axi_rdata  = '0;
        axi_rresp  = 2'b00;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Stream scoreboard and stall-stability monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (st_hold) begin
        chk("out_hold_valid", 32'(out_valid), 32'(1));
        chk("out_hold_data", 32'(out_data), 32'(st_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) flag("out_unexpected");
        else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_last", 32'(out_last), 32'(exp_q[0].l));
          void'(exp_q.pop_front());
        end
        if (first_pending) begin
          first_data    = out_data;
          first_pending = 0;
        end
        if (out_last) last_pop_cyc = cyc;
      end
    end
    st_hold = !reset && out_valid && !out_ready;
    st_data = out_data;
  end

  task automatic start_cmd(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int n;
    logic [AW-1:0] a;
    beat_t b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + AW'(i);
      exp_ar.push_back(a);
      b.d = mem_f(a);
      b.l = (i == int'(len) - 1);
      exp_q.push_back(b);
    end
    first_pending = (len != '0);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    @(negedge clk);
    chk("err_clear_on_accept", 32'(err), 32'(0));
    chk("busy_after_accept", 32'(busy), 32'(len != '0));
  endtask

  task automatic wait_done(input logic [LW-1:0] len, input logic exp_err);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) flag("done_timeout");
    else if (len == '0) begin
      chk("zero_done_latency", cyc - acc_cyc, 32'(0));
      chk("zero_no_arvalid", 32'(axi_arvalid), 32'(0));
      chk("zero_no_out_valid", 32'(out_valid), 32'(0));
    end else chk("done_after_last_pop", cyc, last_pop_cyc + 1);
    chk("stream_all_delivered", 32'(exp_q.size()), 32'(0));
    chk("ar_all_issued", 32'(exp_ar.size()), 32'(0));
    chk("err_at_done", 32'(err), 32'(exp_err));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("idle_after_done", 32'(busy), 32'(0));
    chk("cmd_ready_idle", 32'(cmd_ready), 32'(1));
    repeat (2) @(negedge clk);
    chk("err_sticky", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int base;
    vecs[0] = '{20'h00010, 21'd4, 0, 1'b0, 1'b0, 1'b0, 20'h0,     1'b0, 16'hA5B5};
    vecs[1] = '{20'hFFFFE, 21'd4, 0, 1'b0, 1'b0, 1'b0, 20'h0,     1'b0, 16'h5A5B};
    vecs[2] = '{20'h00300, 21'd3, 0, 1'b0, 1'b0, 1'b1, 20'h00301, 1'b1, 16'hA6A5};
    vecs[3] = '{20'h00500, 21'd7, 1, 1'b1, 1'b1, 1'b0, 20'h0,     1'b0, 16'hA0A5};
    vecs[4] = '{20'h01234, 21'd9, 1, 1'b1, 1'b1, 1'b0, 20'h0,     1'b0, 16'hB791};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_rready", 32'(axi_rready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_arvalid", 32'(axi_arvalid), 32'(0));
    chk("rst_araddr", 32'(axi_araddr), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("post_rst_rready", 32'(axi_rready), 32'(1));

    for (int i = 0; i < 5; i++) begin
      or_mode = vecs[i].or_mode; ar_rand = vecs[i].ar_rand; r_rand = vecs[i].r_rand;
      err_en = vecs[i].err_en; err_addr = vecs[i].err_addr;
      start_cmd(vecs[i].addr, vecs[i].len);
      wait_done(vecs[i].len, vecs[i].exp_err);
      chk("first_word", 32'(first_data), 32'(vecs[i].exp_first));
    end
    or_mode = 0; ar_rand = 0; r_rand = 0; err_en = 0;

    // Backpressure: credits stop issue at FIFO_DEPTH reads.
    or_mode = 2;
    base = ar_cnt;
    start_cmd(20'h00400, 21'd16);
    repeat (20) @(negedge clk);
    chk("bp_ar_count", 32'(ar_cnt - base), 32'(FD));
    chk("bp_arvalid_low", 32'(axi_arvalid), 32'(0));
    or_mode = 0;
    wait_done(21'd16, 1'b0);

    // Zero length, then a command presented while busy is ignored.
    start_cmd(20'h00777, 21'd0);
    wait_done(21'd0, 1'b0);
    start_cmd(20'h00600, 21'd8);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_addr = 20'h05555; cmd_len = 21'd1;
    repeat (4) begin
      @(negedge clk);
      chk("busy_cmd_ready_low", 32'(cmd_ready), 32'(0));
      chk("busy_high", 32'(busy), 32'(1));
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(21'd8, 1'b0);

    // Mid-operation reset: 2 words in the FIFO, 1 read in flight.
    or_mode = 2; ar_allow = 3; r_allow = 2;
    base = ar_cnt;
    start_cmd(20'h00200, 21'd8);
    repeat (15) @(negedge clk);
    chk("mr_ar_count", 32'(ar_cnt - base), 32'(3));
    chk("mr_out_valid_before", 32'(out_valid), 32'(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_ar.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mr_out_valid", 32'(out_valid), 32'(0));
    chk("mr_arvalid", 32'(axi_arvalid), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_cmd_ready", 32'(cmd_ready), 32'(0));
    ar_allow = -1; r_allow = -1; or_mode = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("mr_stray_discarded", 32'(out_valid), 32'(0));
    end
    chk("mr_stray_consumed", 32'(rq.size()), 32'(0));
    start_cmd(20'h00100, 21'd2);
    wait_done(21'd2, 1'b0);
    chk("mr_first_word", 32'(first_data), 32'(16'hA4A5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
